hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit between the ALU operand path (RF_RD1 / ALUSrc_Out) and the HiLo register.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and stalls the PC while busy.
- Delivers a single write strobe and 64-bit {Hi,Lo} word, consumed by HiLoRegister on its WriteEnable/WriteData ports.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clk  in  1  system clock (the divided ClkOut domain); rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  request; level held by the decoded instruction while it sits in IM.
- Op  in  3  operation code (see Behaviour).
- A  in  WIDTH  rs operand / dividend / multiplicand.
- B  in  WIDTH  rt operand / divisor / multiplier.
- HiLoRead  in  2*WIDTH  current {Hi,Lo}; used only by accumulate ops.
- Stall  out  1  hold PC and suppress RegWrite/MemWrite.
- Busy  out  1  state is not IDLE.
- HiLoEn  out  1  one-cycle write strobe to HiLo.
- HiLoWrite  out  2*WIDTH  {Hi,Lo} result, valid when HiLoEn=1.
- DivZero  out  1  pulses with HiLoEn when a divide had B==0.

Behaviour:
- Op encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 1xx are accumulate ops (see Optional Feature). Without the feature they are illegal: Start is ignored and the unit stays IDLE.
- Reset (Rst=0, async): state=IDLE; Stall, Busy, HiLoEn, DivZero = 0; HiLoWrite, counter and datapath registers = 0. Reset mid-operation aborts with no HiLo write.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: Stall = Start & legal(Op), combinational, so the PC is held in the request cycle. On that edge:
    - latch Op and the sign flags: sA = A[31] & signed, sB = B[31] & signed.
    - latch |A| and |B| (two's-complement magnitude when signed; 0x8000_0000 stays 0x8000_0000 as unsigned).
    - load counter = WIDTH; go to CALC.
  - CALC: WIDTH cycles, one bit per cycle; counter decrements; leave when the counter reaches 1.
    - Multiply (shift-add): 65-bit {carry,P}. If P[0], add the multiplicand to P[63:32] with carry; then shift right 1.
    - Divide (restoring): shift {R,Q} left 1; trial R - divisor; if non-negative, keep the difference and set Q[0]=1.
  - FIX: 1 cycle sign correction.
    - Multiply: negate the 64-bit product if sA^sB.
    - Divide: negate Q if sA^sB; negate R if sA.
    - Divide by zero overrides: Hi = A as latched (original signed value), Lo = all-ones, and DivZero is set for DONE.
  - DONE: HiLoEn=1, HiLoWrite = {Hi,Lo}, Stall=0, so the PC advances on this edge. Start is ignored in DONE; go to IDLE.
- Latency and stall:
  - Request cycle to HiLoEn = WIDTH+2 edges (34 at default).
  - Stall is high for WIDTH+2 consecutive cycles, from the request cycle through FIX.
- HiLoWrite holds its last value after DONE; HiLoEn and DivZero are single-cycle.
- Signed overflow (-2^31 / -1): Lo = 0x8000_0000, Hi = 0, no flag.
- Start deasserting during CALC/FIX does not abort the operation.
- Op/A/B changes after acceptance are ignored.

Optional Feature:
- Macro: MULDIV_ACCUM_EN.
- Defined: Op 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU are legal.
  - HiLoRead is sampled in FIX.
  - HiLoWrite = HiLoRead ± signed/unsigned product, computed in one extra ACC state between FIX and DONE. Latency becomes WIDTH+3.
- Undefined: 1xx are illegal as stated above; the HiLoRead port exists but is unused.

Decomposition:
- Package muldiv_pkg:
  - Op code localparams (OP_MULT..OP_MSUBU).
  - State encoding (S_IDLE, S_CALC, S_FIX, S_ACC, S_DONE).
  - Default WIDTH.
  - Helper function is_div(op).
- One sub-module, muldiv_signfix: combinational conditional two's-complement negate of a WIDTH-bit value. Instantiated for the operand magnitudes and for the Q/R/product fix-up.

Test Plan:
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF, Start held -> Stall high 34 cycles; single HiLoEn with HiLoWrite = 0xFFFF_FFFE_0000_0001.
- MULT A=-7, B=6 -> HiLoWrite = 0xFFFF_FFFF_FFFF_FFD6. DIV A=-7, B=2 -> Hi = 0xFFFF_FFFF (-1), Lo = 0xFFFF_FFFD (-3).
- DIVU A=100, B=0 -> Hi = 100, Lo = 0xFFFF_FFFF, DivZero=1 in the HiLoEn cycle. DIV A=0x8000_0000, B=-1 -> Lo = 0x8000_0000, Hi = 0.
- Rst pulsed low at CALC cycle 10 -> all outputs 0 immediately; no HiLoEn. After release, a new MULTU 3×5 -> HiLoWrite = 15.
- Start held through DONE, then a back-to-back second request on the next cycle -> exactly one HiLoEn per request; second result correct.
- With MULDIV_ACCUM_EN: HiLoRead = 10, MSUB A=3, B=4 -> HiLoWrite = -2 (0xFFFF_FFFF_FFFF_FFFE), latency 35. Without the macro: Op=100 -> Stall and Busy stay 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - operation codes for the Op input
//   - FSM state encoding
//   - default datapath width and iteration-counter width
//   - small decode helpers on the operation code
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // DIV / DIVU
    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    // Even codes are the signed flavours of every operation.
    function automatic logic is_signed_op(input logic [2:0] op);
        return ~op[0];
    endfunction

    // MADD / MADDU / MSUB / MSUBU
    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    // MSUB / MSUBU
    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate.
// Ports:
//   neg  - when 1, dout = -din; otherwise dout = din
//   din  - WIDTH-bit input value
//   dout - WIDTH-bit result
// Used both to take operand magnitudes and to restore result signs.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? ((~din) + WIDTH'(1)) : din;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit feeding the HiLo register.
// One result bit per cycle: request, WIDTH CALC cycles, one FIX cycle,
// then a single-cycle HiLo write strobe in DONE.
//
// Ports:
//   Clk       - rising-edge clock
//   Rst       - asynchronous active-low reset
//   Start     - operation request (level, held by the decoded instruction)
//   Op        - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate ops
//   A, B      - rs / rt operands
//   HiLoRead  - current {Hi,Lo}, used only by accumulate ops
//   Stall     - hold the PC and suppress register/memory writes
//   Busy      - FSM is not idle
//   HiLoEn    - one-cycle write strobe to HiLo
//   HiLoWrite - {Hi,Lo} result; holds its last value between writes
//   DivZero   - pulses together with HiLoEn when a divide had B == 0
//
// Build option: define MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU,
// which add one ACC cycle between FIX and DONE. Without it, 1xx codes are
// ignored and HiLoRead is unused.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [2:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2*WIDTH-1:0] HiLoRead,
    output logic               Stall,
    output logic               Busy,
    output logic               HiLoEn,
    output logic [2*WIDTH-1:0] HiLoWrite,
    output logic               DivZero
);

    // Handshake: a request is Start=1 with a legal Op while idle. It is
    // accepted on the edge ending that cycle; Stall is high from the
    // request cycle until the result is written, and the caller may only
    // move on in the HiLoEn cycle (Stall=0). Start is not sampled again
    // until the FSM is back in IDLE.

    state_e state_q, state_d;

    logic [2:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;       // product high half / remainder
    logic [WIDTH-1:0]   lo_q, lo_d;       // product low half / quotient
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic               dz_q, dz_d;
`ifdef MULDIV_ACCUM_EN
    logic [2*WIDTH-1:0] acc_in_q, acc_in_d;
`endif

    logic               op_legal;
    logic               req;
    logic               neg_a_in, neg_b_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;
    logic               unused_bits;

`ifdef MULDIV_ACCUM_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~Op[2];
`endif

    assign req = Start & op_legal;

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly its magnitude.
    assign neg_a_in = A[WIDTH-1] & is_signed_op(Op);
    assign neg_b_in = B[WIDTH-1] & is_signed_op(Op);

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .neg  (neg_a_in),
        .din  (A),
        .dout (mag_a_in)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .neg  (neg_b_in),
        .din  (B),
        .dout (mag_b_in)
    );

    // Sign restoration of the unsigned results.
    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg  (sa_q ^ sb_q),
        .din  ({hi_q, lo_q}),
        .dout (prod_fixed)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .neg  (sa_q ^ sb_q),
        .din  (lo_q),
        .dout (quo_fixed)
    );

    // Remainder takes the sign of the dividend.
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .neg  (sa_q),
        .din  (hi_q),
        .dout (rem_fixed)
    );

    // Shift-add step: the carry out of the upper-half add becomes the new
    // top bit after the right shift.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);

    // Restoring-divide step on the left-shifted partial remainder.
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, mag_b_q});
    assign div_diff = div_sh - {1'b0, mag_b_q};

    // ---------------- state register ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req) state_d = S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
`ifdef MULDIV_ACCUM_EN
            S_FIX:  state_d = is_acc(op_q) ? S_ACC : S_DONE;
            S_ACC:  state_d = S_DONE;
`else
            S_FIX:  state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        Stall     = 1'b0;
        Busy      = (state_q != S_IDLE);
        HiLoEn    = (state_q == S_DONE);
        DivZero   = (state_q == S_DONE) & dz_q;
        HiLoWrite = hilo_q;
        case (state_q)
            // Combinational so the PC is held in the request cycle itself;
            // gated by reset so an asserted reset forces Stall low.
            S_IDLE:  Stall = req & Rst;
            S_DONE:  Stall = 1'b0;
            default: Stall = 1'b1;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_raw_d = a_raw_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        hilo_d  = hilo_q;
        dz_d    = dz_q;
`ifdef MULDIV_ACCUM_EN
        acc_in_d = acc_in_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = Op;
                    sa_d    = neg_a_in;
                    sb_d    = neg_b_in;
                    a_raw_d = A;
                    mag_a_d = mag_a_in;
                    mag_b_d = mag_b_in;
                    cnt_d   = CNT_W'(WIDTH);
                    dz_d    = 1'b0;
                    hi_d    = '0;
                    // Divide shifts the dividend out of Q; multiply shifts
                    // the multiplier out of the low half.
                    lo_d    = is_div(Op) ? mag_a_in : mag_b_in;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div(op_q)) begin
                    if (div_ge) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (is_div(op_q)) begin
                    if (mag_b_q == '0) begin
                        hilo_d = {a_raw_q, {WIDTH{1'b1}}};
                        dz_d   = 1'b1;
                    end else begin
                        hilo_d = {rem_fixed, quo_fixed};
                    end
`ifdef MULDIV_ACCUM_EN
                end else if (is_acc(op_q)) begin
                    // Keep the signed product and snapshot HiLo for ACC.
                    {hi_d, lo_d} = prod_fixed;
                    acc_in_d     = HiLoRead;
`endif
                end else begin
                    hilo_d = prod_fixed;
                end
            end
`ifdef MULDIV_ACCUM_EN
            S_ACC: begin
                hilo_d = is_sub(op_q) ? (acc_in_q - {hi_q, lo_q})
                                      : (acc_in_q + {hi_q, lo_q});
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_raw_q <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            hilo_q  <= '0;
            dz_q    <= 1'b0;
`ifdef MULDIV_ACCUM_EN
            acc_in_q <= '0;
`endif
        end else begin
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_raw_q <= a_raw_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            dz_q    <= dz_d;
`ifdef MULDIV_ACCUM_EN
            acc_in_q <= acc_in_d;
`endif
        end
    end

    // Signedness is resolved at acceptance, so op_q[0] is never read; the
    // top bit of div_diff is only meaningful when it is discarded.
    assign unused_bits = ^{HiLoRead, op_q[0], div_diff[WIDTH]};

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] HiLoRead;
  logic        Stall;
  logic        Busy;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic        DivZero;

`ifdef MULDIV_ACCUM_EN
  localparam int LAT = 35;
  localparam int CAP = 3;
`else
  localparam int LAT = 34;
  localparam int CAP = 2;
`endif

  int errors = 0;
  int checks = 0;

  hilo_muldiv_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HiLoRead  (HiLoRead),
    .Stall     (Stall),
    .Busy      (Busy),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .DivZero   (DivZero)
  );

  // ---------------- clock / watchdog ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic op_legal(input logic [2:0] op);
`ifdef MULDIV_ACCUM_EN
    return 1'b1;
`else
    return ~op[2];
`endif
  endfunction

  // Architectural result from plain 64-bit arithmetic.
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hl,
                                               output logic dz);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, sprod, uprod, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sprod = 64'(sa * sb);
    uprod = ua * ub;
    dz = 1'b0;
    case (op)
      3'b000: return sprod;
      3'b001: return uprod;
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          return {a, 32'hFFFF_FFFF};
        end
        if (op[0]) begin
          q = ua / ub;
          r = ua % ub;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          q = 64'(sq);
          r = 64'(sr);
        end
        return {r[31:0], q[31:0]};
      end
      3'b100: return hl + sprod;
      3'b101: return hl + uprod;
      3'b110: return hl - sprod;
      default: return hl - uprod;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [63:0] exp_q[$];
  int          left = 0;
  logic [2:0]  pend_op = '0;
  logic [31:0] pend_a = '0;
  logic [31:0] pend_b = '0;
  logic        pend_dz = 1'b0;
  logic [63:0] last_res = '0;
  int          model_done = 0;
  int          dut_en = 0;

  always @(negedge Clk) begin
    logic e_stall, e_busy, e_en, e_dz, dzv;
    logic [63:0] v;
    e_stall = 1'b0;
    e_busy  = 1'b0;
    e_en    = 1'b0;
    e_dz    = 1'b0;
    if (HiLoEn === 1'b1) dut_en++;
    if (!Rst) begin
      left = 0;
      last_res = '0;
      exp_q.delete();
    end else if (left == 0) begin
      e_stall = Start && op_legal(Op);
      if (e_stall) begin
        left = LAT;
        pend_op = Op;
        pend_a = A;
        pend_b = B;
      end
    end else if (left == 1) begin
      e_busy = 1'b1;
      e_en = 1'b1;
      e_dz = pend_dz;
      model_done++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expected result queued at %0t", $time);
      end else begin
        last_res = exp_q.pop_front();
      end
      left = 0;
    end else begin
      e_stall = 1'b1;
      e_busy = 1'b1;
      if (left == CAP) begin
        v = model_result(pend_op, pend_a, pend_b, HiLoRead, dzv);
        exp_q.push_back(v);
        pend_dz = dzv;
      end
      left--;
    end
    check("stall", 64'(Stall), 64'(e_stall));
    check("busy", 64'(Busy), 64'(e_busy));
    check("hiloen", 64'(HiLoEn), 64'(e_en));
    check("divzero", 64'(DivZero), 64'(e_dz));
    check("hilowrite", HiLoWrite, last_res);
  end

  // ---------------- driver ----------------
  // Called at 2 time units after a rising edge. Unless b2b, waits one
  // cycle so the unit is idle when the request appears.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hl, input bit b2b,
                        input bit keep, input bit chk, input logic [63:0] exp_val,
                        input bit exp_dz);
    int n;
    bit seen;
    if (!b2b) begin
      @(posedge Clk);
      #2;
    end
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    HiLoRead = hl;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
      if (HiLoEn === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no HiLoEn within %0d cycles", name, n);
    end else if (chk) begin
      check({name, "_latency"}, 64'(n), 64'(b2b ? LAT + 1 : LAT));
      check({name, "_value"}, HiLoWrite, exp_val);
      check({name, "_divzero"}, 64'(DivZero), 64'(exp_dz));
    end
    #1;
    if (!keep) Start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic dzp;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic [63:0] rhl;
    bit prev_keep;
    bit rkeep;

    Rst = 1'b0;
    Start = 1'b0;
    Op = 3'b000;
    A = '0;
    B = '0;
    HiLoRead = '0;

    // Model pins against hand-computed values.
    check("model_multu", model_result(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, dzp),
          64'hFFFF_FFFE_0000_0001);
    check("model_mult", model_result(3'b000, 32'hFFFF_FFF9, 32'd6, 64'd0, dzp),
          64'hFFFF_FFFF_FFFF_FFD6);
    check("model_div", model_result(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, dzp),
          64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divz", model_result(3'b011, 32'd100, 32'd0, 64'd0, dzp),
          64'h0000_0064_FFFF_FFFF);
    check("model_divz_flag", 64'(dzp), 64'd1);
    check("model_ovf", model_result(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, dzp),
          64'h0000_0000_8000_0000);
    check("model_msub", model_result(3'b110, 32'd3, 32'd4, 64'd10, dzp),
          64'hFFFF_FFFF_FFFF_FFFE);

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    check("rst_stall", 64'(Stall), 64'd0);
    check("rst_hilowrite", HiLoWrite, 64'd0);
    #1;
    Rst = 1'b1;

    // Directed operations.
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0, 0, 1,
           64'hFFFF_FFFE_0000_0001, 0);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFF9, 32'd6, 64'd0, 0, 0, 1,
           64'hFFFF_FFFF_FFFF_FFD6, 0);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, 0, 0, 1,
           64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu_zero", 3'b011, 32'd100, 32'd0, 64'd0, 0, 0, 1,
           64'h0000_0064_FFFF_FFFF, 1);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0, 0, 1,
           64'h0000_0000_8000_0000, 0);

    // Reset in the middle of CALC aborts the operation.
    @(posedge Clk);
    #2;
    Start = 1'b1;
    Op = 3'b001;
    A = 32'd12345;
    B = 32'd678;
    repeat (11) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check("abort_stall", 64'(Stall), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hiloen", 64'(HiLoEn), 64'd0);
    check("abort_divzero", 64'(DivZero), 64'd0);
    check("abort_hilowrite", HiLoWrite, 64'd0);
    Start = 1'b0;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    run_op("multu_small", 3'b001, 32'd3, 32'd5, 64'd0, 0, 0, 1, 64'd15, 0);

    // Back-to-back with Start held through DONE.
    run_op("b2b_first", 3'b000, 32'd5, 32'hFFFF_FFFD, 64'd0, 0, 1, 1,
           64'hFFFF_FFFF_FFFF_FFF1, 0);
    run_op("b2b_second", 3'b011, 32'd1000, 32'd7, 64'd0, 1, 0, 1,
           {32'd6, 32'd142}, 0);

`ifdef MULDIV_ACCUM_EN
    run_op("msub", 3'b110, 32'd3, 32'd4, 64'd10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
`else
    @(posedge Clk);
    #2;
    Start = 1'b1;
    Op = 3'b100;
    A = 32'd3;
    B = 32'd4;
    repeat (4) begin
      @(posedge Clk);
      #1;
      check("illegal_stall", 64'(Stall), 64'd0);
      check("illegal_busy", 64'(Busy), 64'd0);
    end
    #1;
    Start = 1'b0;
`endif

    // Randomized operations, checked cycle by cycle by the compare process.
    prev_keep = 0;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rhl = {$urandom(), $urandom()};
      rkeep = bit'($urandom_range(0, 1));
      if (op_legal(rop)) begin
        run_op("rand", rop, ra, rb, rhl, prev_keep, rkeep, 0, 64'd0, 0);
        prev_keep = rkeep;
      end else begin
        Start = 1'b1;
        Op = rop;
        A = ra;
        B = rb;
        repeat (3) begin
          @(posedge Clk);
          #1;
          check("rand_illegal_busy", 64'(Busy), 64'd0);
        end
        #1;
        Start = 1'b0;
        prev_keep = 0;
      end
    end
    Start = 1'b0;

    repeat (40) @(posedge Clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_strobe_count", 64'(dut_en), 64'(model_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
